// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential imem fetch over req/ack,
// buffered in a small FIFO and handed to decode via valid/ready.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;

  logic [31:0]   mem_pc_q  [DEPTH];
  logic [31:0]   mem_ins_q [DEPTH];

  logic          issue;
  logic          accept;
  logic          push;
  logic          pop;

  always_comb begin
    issue     = !outstanding_q && !redirect && (count_q != FULL);
    imem_req  = !reset && (outstanding_q || issue);
    // a held request keeps its own address even after a redirect
    imem_addr = outstanding_q ? req_addr_q : fetch_pc_q;
    accept    = imem_req && imem_ack;
    push      = accept && !discard_q && !redirect;

    instr_valid = !reset && !redirect && (count_q != '0);
    pop         = instr_valid && instr_ready;
    instr       = instr_valid ? mem_ins_q[rd_ptr_q] : NOP;
    instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q] : 32'h0;

    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = imem_req ? imem_addr : req_addr_q;
    outstanding_d = imem_req && !imem_ack;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (accept) begin
      discard_d = 1'b0;
    end else if (redirect && outstanding_q) begin
      discard_d = 1'b1;
    end

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // storage is only read through count-qualified pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]  <= imem_addr;
      mem_ins_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
